// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle instruction sequencer: opcode classes,
// FSM state encoding and the decoded instruction class.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The encoding is visible on the debug state port, so the values are pinned.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ClsNone,
    ClsR,
    ClsI,
    ClsLoad,
    ClsStore,
    ClsBranch
  } instr_class_e;

endpackage

// File: rtl/multicycle_ctrl_instr_class_decode.sv
// Combinational opcode classifier, shared by the sequencer and the ALU control.
module instr_class_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output instr_class_e class_o,
  output logic         legal_o
);

  // Map the major opcode onto an instruction class; anything else is illegal.
  always_comb begin
    class_o = ClsNone;
    legal_o = 1'b1;
    case (opcode_i)
      OP_R:      class_o = ClsR;
      OP_I:      class_o = ClsI;
      OP_LOAD:   class_o = ClsLoad;
      OP_STORE:  class_o = ClsStore;
      OP_BRANCH: class_o = ClsBranch;
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes, counts retired instructions and halts on a memory timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic            branchTaken,
  input  logic            memReady,
  output logic [2:0]      state,
  output logic            pcWrite,
  output logic            irWrite,
  output logic            regWrite,
  output logic            memRead,
  output logic            memWrite,
  output logic            instrDone,
  output logic            illegal,
  output logic            memErr,
  output logic [XLEN-1:0] retired
);

  localparam int unsigned WaitW = 4;
  // The timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic            mem_err_q, mem_err_d;
  logic [XLEN-1:0] retired_q, retired_d;

  instr_class_e    cls;
  logic            legal;
  logic            timeout;
  state_e          next_instr;

  instr_class_decode u_decode (
    .opcode_i (opcode),
    .class_o  (cls),
    .legal_o  (legal)
  );

  assign timeout    = (wait_q == WaitLast);
  assign next_instr = run ? ST_FETCH : ST_IDLE;

  // State, wait counter, sticky error and retirement count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and strobe decode; the wait count clears whenever the state moves.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    mem_err_d = mem_err_q;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    instrDone = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          // Illegal opcodes end the instruction without retiring it.
          illegal = 1'b1;
          state_d = next_instr;
        end
      end
      ST_EXEC: begin
        case (cls)
          ClsLoad, ClsStore: state_d = ST_MEM;
          ClsBranch: begin
            pcWrite   = branchTaken;
            instrDone = 1'b1;
            state_d   = next_instr;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (cls == ClsStore) memWrite = 1'b1;
        else                 memRead  = 1'b1;
        if (memReady) begin
          if (cls == ClsStore) begin
            instrDone = 1'b1;
            state_d   = next_instr;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WB: begin
        regWrite  = |rd;  // writes to x0 are dropped
        instrDone = 1'b1;
        state_d   = next_instr;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign retired_d = retired_q + XLEN'(instrDone);

  assign state   = state_q;
  assign memErr  = mem_err_q;
  assign retired = retired_q;

endmodule
